// File: rtl/alu_arbiter_if.sv
// Bundles the two request channels, the tagged response channel and the alu_top
// operand/result wires. The arbiter uses the slave modport; requesters and the ALU side use master.
interface alu_arbiter_if #(
    parameter int width = 6
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [width-1:0]     req0_a;
    logic [width-1:0]     req0_b;
    logic [1:0]           req0_func;

    logic                 req1_valid;
    logic                 req1_ready;
    logic [width-1:0]     req1_a;
    logic [width-1:0]     req1_b;
    logic [1:0]           req1_func;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [2*width-1:0]   rsp_out;
    logic                 rsp_ovf;

    logic [width-1:0]     alu_a;
    logic [width-1:0]     alu_b;
    logic [1:0]           alu_func;
    logic [2*width-1:0]   alu_out;
    logic                 alu_ovf;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_func,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_func,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_out, rsp_ovf,
        input  rsp_ready,
        output alu_a, alu_b, alu_func,
        input  alu_out, alu_ovf
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_func,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_func,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_out, rsp_ovf,
        output rsp_ready,
        input  alu_a, alu_b, alu_func,
        output alu_out, alu_ovf
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one alu_top between two requesters: captures operands,
// waits the per-function settle time, then returns the result tagged with the requester id.
module alu_arbiter #(
    parameter int width   = 6,
    parameter int MUL_CYC = 2,
    parameter int DIV_CYC = 4
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    localparam int MAX_L = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int CNT_W = (MAX_L > 1) ? $clog2(MAX_L) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             grant_vld;
    logic             grant_id;
    logic             accept;
    logic [width-1:0] sel_a;
    logic [width-1:0] sel_b;
    logic [1:0]       sel_func;

    // EXEC length minus one, loaded into cnt on accept
    function automatic logic [CNT_W-1:0] exec_len_m1(input logic [1:0] func);
        case (func)
            2'b10:   return CNT_W'(MUL_CYC - 1);
            2'b11:   return CNT_W'(DIV_CYC - 1);
            default: return '0;
        endcase
    endfunction

    always_comb begin
        grant_vld = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last;
        end else begin
            grant_id = bus.req1_valid;
        end
        sel_a    = grant_id ? bus.req1_a    : bus.req0_a;
        sel_b    = grant_id ? bus.req1_b    : bus.req0_b;
        sel_func = grant_id ? bus.req1_func : bus.req0_func;
        accept   = (state == IDLE) && grant_vld;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)        state_nxt = EXEC;
            EXEC:    if (cnt == '0)     state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = accept && !grant_id;
        bus.req1_ready = accept &&  grant_id;
        bus.rsp_valid  = (state == RESP);
    end

    // Operand capture, settle countdown and result capture; last doubles as the in-flight id
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            last         <= 1'b1;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_func <= '0;
            bus.rsp_out  <= '0;
            bus.rsp_ovf  <= 1'b0;
            bus.rsp_id   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.alu_a    <= sel_a;
                        bus.alu_b    <= sel_b;
                        bus.alu_func <= sel_func;
                        last         <= grant_id;
                        cnt          <= exec_len_m1(sel_func);
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        bus.rsp_out <= bus.alu_out;
                        bus.rsp_ovf <= bus.alu_ovf |
                                       ((bus.alu_func == 2'b11) && (bus.alu_b == '0));
                        bus.rsp_id  <= last;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: stand-in alu_top, directed scenarios, then randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int W       = 6;
    localparam int OW      = 2 * W;
    localparam int MUL_CYC = 2;
    localparam int DIV_CYC = 4;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter_if #(.width(W)) bus ();

    alu_arbiter #(
        .width  (W),
        .MUL_CYC(MUL_CYC),
        .DIV_CYC(DIV_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Stand-in alu_top: returns {ovf, out}; div by zero gives {all ones, a} with ovf clear
    function automatic logic [OW:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] f);
        logic [W:0] s;
        case (f)
            2'b00: begin s = {1'b0, a} + {1'b0, b}; return {s[W], {W{1'b0}}, s[W-1:0]}; end
            2'b01: begin s = {1'b0, a} - {1'b0, b}; return {s[W], {W{1'b0}}, s[W-1:0]}; end
            2'b10: return {1'b0, OW'(a) * OW'(b)};
            default: begin
                if (b == '0) return {1'b0, {W{1'b1}}, a};
                return {1'b0, W'(a / b), W'(a % b)};
            end
        endcase
    endfunction

    always_comb {bus.alu_ovf, bus.alu_out} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_func);

    function automatic logic [OW:0] exp_rsp(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] f);
        logic [OW:0] r;
        r = alu_fn(a, b, f);
        if (f == 2'b11 && b == '0) r[OW] = 1'b1;
        return r;
    endfunction

    function automatic int op_len(input logic [1:0] f);
        if (f == 2'b10) return MUL_CYC;
        if (f == 2'b11) return DIV_CYC;
        return 1;
    endfunction

    // Reference model state: one outstanding operation, its due cycle and the visible registers
    bit           m_busy = 1'b0;
    bit           m_last = 1'b1;
    int           m_due = 0;
    logic [OW:0]  m_pend = '0;
    logic         m_pid = 1'b0;
    logic [OW-1:0] cur_out = '0;
    logic         cur_ovf = 1'b0;
    logic         cur_id = 1'b0;
    logic [W-1:0] cur_a = '0;
    logic [W-1:0] cur_b = '0;
    logic [1:0]   cur_f = '0;
    bit           hs0 = 1'b0;
    bit           hs1 = 1'b0;
    int           rsp_ids[$];

    always @(negedge clk) begin : model
        logic ev;
        logic v0;
        logic v1;
        logic gid;
        hs0 = 1'b0;
        hs1 = 1'b0;
        v0  = bus.req0_valid;
        v1  = bus.req1_valid;
        if (rst) begin
            m_busy = 1'b0; m_last = 1'b1;
            cur_out = '0; cur_ovf = 1'b0; cur_id = 1'b0;
            cur_a = '0; cur_b = '0; cur_f = '0;
        end else begin
            ev = m_busy && (cyc >= m_due);
            if (ev) begin
                cur_out = m_pend[OW-1:0];
                cur_ovf = m_pend[OW];
                cur_id  = m_pid;
            end
            chk("rsp_valid", bus.rsp_valid, ev);
            chk("rsp_out", bus.rsp_out, cur_out);
            chk("rsp_ovf", bus.rsp_ovf, cur_ovf);
            chk("rsp_id", bus.rsp_id, cur_id);
            chk("alu_a", bus.alu_a, cur_a);
            chk("alu_b", bus.alu_b, cur_b);
            chk("alu_func", bus.alu_func, cur_f);
            if (m_busy) begin
                chk("ready0_busy", bus.req0_ready, 0);
                chk("ready1_busy", bus.req1_ready, 0);
            end else if (v0 || v1) begin
                gid = (v0 && v1) ? !m_last : v1;
                chk("ready0_idle", bus.req0_ready, !gid);
                chk("ready1_idle", bus.req1_ready, gid);
            end
            if (ev && bus.rsp_ready) begin
                m_busy = 1'b0;
                rsp_ids.push_back(int'(bus.rsp_id));
            end else if (!m_busy && (v0 || v1)) begin
                gid = (v0 && v1) ? !m_last : v1;
                cur_a = gid ? bus.req1_a : bus.req0_a;
                cur_b = gid ? bus.req1_b : bus.req0_b;
                cur_f = gid ? bus.req1_func : bus.req0_func;
                m_pend = exp_rsp(cur_a, cur_b, cur_f);
                m_due  = cyc + op_len(cur_f) + 1;
                m_busy = 1'b1;
                m_last = gid;
                m_pid  = gid;
                hs0    = !gid;
                hs1    = gid;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        for (int i = 0; i < 30 && m_busy; i++) tick();
        chk("drain_idle", m_busy, 0);
        tick();
    endtask

    // Issue one op on port p, wait for acceptance and the first rsp_valid cycle
    task automatic do_op(input string tag, input bit p, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [1:0] f, output int lat,
                         output logic [OW-1:0] out, output logic ovf, output logic id);
        int acc_c;
        bit got;
        lat = -1; out = '0; ovf = 1'b0; id = 1'b0; acc_c = 0;
        if (p) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_func = f; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_func = f; bus.req0_valid = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (p ? bus.req1_ready : bus.req0_ready) begin got = 1'b1; acc_c = cyc; end
        end
        chk({tag, "_accept"}, got, 1);
        tick();
        if (p) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
        if (!got) return;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = 1'b1; lat = cyc - acc_c;
                out = bus.rsp_out; ovf = bus.rsp_ovf; id = bus.rsp_id;
            end
        end
        chk({tag, "_response"}, got, 1);
    endtask

    function automatic logic [W-1:0] rnd_b();
        if ($urandom_range(5) == 0) return '0;
        return W'($urandom);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [OW-1:0] out;
        logic        ovf;
        logic        id;
        logic [OW-1:0] held;
        bit          got;

        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_func = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_func = '0;
        bus.rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_out", bus.rsp_out, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_ovf", bus.rsp_ovf, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_func", bus.alu_func, 0);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        tick();

        // T2: continuous contention alternates starting with port 0
        bus.rsp_ready = 1'b1;
        bus.req0_a = 6'd10; bus.req0_b = 6'd3; bus.req0_func = 2'b00;
        bus.req1_a = 6'd20; bus.req1_b = 6'd4; bus.req1_func = 2'b01;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int i = 0; i < 200 && rsp_ids.size() < 8; i++) @(posedge clk);
        #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        chk("t2_count", rsp_ids.size(), 8);
        for (int i = 0; i < 8 && i < rsp_ids.size(); i++) chk("t2_id_seq", rsp_ids[i], i % 2);
        drain();

        // T1 add
        do_op("t1", 1'b0, 6'd5, 6'd3, 2'b00, lat, out, ovf, id);
        chk("t1_lat", lat, 2); chk("t1_out", out, 12'd8);
        chk("t1_ovf", ovf, 0); chk("t1_id", id, 0);
        drain();

        // T3 div, then div by zero
        do_op("t3", 1'b1, 6'd45, 6'd7, 2'b11, lat, out, ovf, id);
        chk("t3_lat", lat, 5); chk("t3_out", out, 12'h183);
        chk("t3_ovf", ovf, 0); chk("t3_id", id, 1);
        drain();
        do_op("t3z", 1'b0, 6'd9, 6'd0, 2'b11, lat, out, ovf, id);
        chk("t3z_lat", lat, 5); chk("t3z_out", out, 12'hFC9); chk("t3z_ovf", ovf, 1);
        drain();

        // T4 mul
        do_op("t4", 1'b0, 6'd63, 6'd63, 2'b10, lat, out, ovf, id);
        chk("t4_lat", lat, 3); chk("t4_out", out, 12'hF81); chk("t4_ovf", ovf, 0);
        drain();

        // T5 response back-pressure with a waiting requester
        bus.rsp_ready = 1'b0;
        do_op("t5", 1'b0, 6'd7, 6'd9, 2'b00, lat, out, ovf, id);
        held = out;
        chk("t5_out", held, 12'd16);
        bus.req1_a = 6'd1; bus.req1_b = 6'd1; bus.req1_func = 2'b00; bus.req1_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", bus.rsp_valid, 1);
            chk("t5_hold_out", bus.rsp_out, held);
            chk("t5_hold_ready1", bus.req1_ready, 0);
        end
        tick();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_idle_next", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        drain();

        // T6 reset mid-EXEC of a div
        bus.req1_a = 6'd45; bus.req1_b = 6'd7; bus.req1_func = 2'b11; bus.req1_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.req1_ready;
        end
        chk("t6_accept", got, 1);
        tick();
        bus.req1_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rsp_valid", bus.rsp_valid, 0);
        chk("t6_rsp_out", bus.rsp_out, 0);
        chk("t6_rsp_id", bus.rsp_id, 0);
        chk("t6_alu_a", bus.alu_a, 0);
        chk("t6_alu_b", bus.alu_b, 0);
        chk("t6_alu_func", bus.alu_func, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t6_no_rsp", bus.rsp_valid, 0);
        end
        tick();
        bus.req0_a = 6'd2; bus.req0_b = 6'd2; bus.req0_func = 2'b00;
        bus.req1_a = 6'd3; bus.req1_b = 6'd3; bus.req1_func = 2'b00;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        @(negedge clk);
        chk("t6_grant0", bus.req0_ready, 1);
        chk("t6_grant1", bus.req1_ready, 0);
        tick();
        drain();

        // Randomized traffic: random valids, drops, back-pressure and rare resets
        for (int c = 0; c < 1500; c++) begin
            tick();
            rst = ($urandom_range(299) == 0);
            bus.rsp_ready = ($urandom_range(3) != 0);
            if (hs0 || !bus.req0_valid) begin
                bus.req0_valid = $urandom_range(1) != 0;
                bus.req0_a = W'($urandom); bus.req0_b = rnd_b(); bus.req0_func = 2'($urandom);
            end else if ($urandom_range(7) == 0) begin
                bus.req0_valid = 1'b0;
            end
            if (hs1 || !bus.req1_valid) begin
                bus.req1_valid = $urandom_range(1) != 0;
                bus.req1_a = W'($urandom); bus.req1_b = rnd_b(); bus.req1_func = 2'($urandom);
            end else if ($urandom_range(7) == 0) begin
                bus.req1_valid = 1'b0;
            end
        end
        rst = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
